fivesons_game_ctrl: RTL and testbench

//  Turn sequencer and win detector for the FiveSons gomoku board. Takes one-cycle

---
 rtl/fivesons_game_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_fivesons_game_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fivesons_game_ctrl.sv
// fivesons_game_ctrl: turn sequencer and win detector for the FiveSons gomoku
// board. Owns the board register, cursor, turn and game status. After every
// placement it walks the 8 rays around the new stone, one cell per cycle, and
// decides win, draw or next turn.
module fivesons_game_ctrl #(
  parameter int BOARD_N = 16,
  parameter int COORD_W = 4,
  parameter int WIN_LEN = 5
) (
  input  logic                           Clck,
  input  logic                           Reset,
  input  logic                           new_game,
  input  logic                           btn_up,
  input  logic                           btn_down,
  input  logic                           btn_left,
  input  logic                           btn_right,
  input  logic                           btn_place,
  output logic [2*BOARD_N*BOARD_N-1:0]   board,
  output logic [COORD_W-1:0]             pointer_loc_x,
  output logic [COORD_W-1:0]             pointer_loc_y,
  output logic [1:0]                     gaming_status,
  output logic                           turn,
  output logic                           busy
);

  localparam int CELLS  = BOARD_N * BOARD_N;
  localparam int BRD_W  = 2 * CELLS;
  localparam int CNT_W  = $clog2(CELLS + 1);
  localparam int STEP_W = $clog2(WIN_LEN);
  localparam int RUN_W  = $clog2(2 * WIN_LEN);
  // Probe coordinates get two extra bits so that stepping off either edge
  // shows up as a non-zero upper field instead of wrapping onto the board.
  localparam int PRB_W  = COORD_W + 2;
  localparam int IDX_W  = 2 * COORD_W + 1;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIN_LEN - 1);
  localparam logic [RUN_W-1:0]  WIN_RUN   = RUN_W'(WIN_LEN);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(CELLS);

  typedef enum logic [1:0] {IDLE, CHECK, EVAL, OVER} state_t;

  // Rays are ordered so that each axis is an even/odd pair.
  typedef enum logic [2:0] {
    DIR_E, DIR_W, DIR_S, DIR_N, DIR_SE, DIR_NW, DIR_SW, DIR_NE
  } dir_t;

  state_t              state_q;
  logic [BRD_W-1:0]    board_q;
  logic [COORD_W-1:0]  ptr_x_q, ptr_y_q;
  logic [1:0]          status_q;
  logic                turn_q;
  logic                busy_q;
  logic [CNT_W-1:0]    count_q;

  // Scan context for the stone being checked.
  logic [COORD_W-1:0]  org_x_q, org_y_q;
  logic [1:0]          color_q;
  dir_t                dir_q;
  logic [STEP_W-1:0]   step_q;
  logic [RUN_W-1:0]    run_q;
  logic                win_q;

  logic [PRB_W-1:0]    ox, oy, off;
  logic [PRB_W-1:0]    probe_x, probe_y;
  logic                probe_in;
  logic [IDX_W-1:0]    probe_idx;
  logic [1:0]          probe_cell;
  logic                match;
  logic                ray_end;
  logic [RUN_W-1:0]    run_d;

  logic [IDX_W-1:0]    ptr_idx;
  logic                ptr_empty;
  logic [1:0]          stone;

  assign ox  = PRB_W'(org_x_q);
  assign oy  = PRB_W'(org_y_q);
  assign off = PRB_W'(step_q);

  // Probe position: origin plus step_q cells along the current ray.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and infers a latch.
    probe_x = ox;
    probe_y = oy;
    case (dir_q)
      DIR_E:  probe_x = ox + off;
      DIR_W:  probe_x = ox - off;
      DIR_S:  probe_y = oy + off;
      DIR_N:  probe_y = oy - off;
      DIR_SE: begin probe_x = ox + off; probe_y = oy + off; end
      DIR_NW: begin probe_x = ox - off; probe_y = oy - off; end
      DIR_SW: begin probe_x = ox - off; probe_y = oy + off; end
      DIR_NE: begin probe_x = ox + off; probe_y = oy - off; end
      default: ;
    endcase
  end

  assign probe_in   = (probe_x[PRB_W-1:COORD_W] == '0) &&
                      (probe_y[PRB_W-1:COORD_W] == '0);
  assign probe_idx  = {probe_y[COORD_W-1:0], probe_x[COORD_W-1:0], 1'b0};
  assign probe_cell = board_q[probe_idx +: 2];
  assign match      = probe_in && (probe_cell == color_q);
  assign run_d      = match ? run_q + RUN_W'(1) : run_q;
  assign ray_end    = !match || (step_q == LAST_STEP);

  assign ptr_idx    = {ptr_y_q, ptr_x_q, 1'b0};
  assign ptr_empty  = (board_q[ptr_idx +: 2] == 2'b00);
  assign stone      = turn_q ? 2'b10 : 2'b01;

  // Game FSM: button handling, placement, ray scan and result evaluation.
  always_ff @(posedge Clck or posedge Reset) begin
    if (Reset) begin
      // NOTE: the board is a plain flop array driven straight to the display,
      // not a RAM, so it can and must be cleared by reset.
      board_q  <= '0;
      ptr_x_q  <= COORD_W'(4);
      ptr_y_q  <= COORD_W'(6);
      status_q <= 2'b00;
      turn_q   <= 1'b0;
      busy_q   <= 1'b0;
      count_q  <= '0;
      state_q  <= IDLE;
      org_x_q  <= '0;
      org_y_q  <= '0;
      color_q  <= 2'b00;
      dir_q    <= DIR_E;
      step_q   <= STEP_W'(1);
      run_q    <= RUN_W'(1);
      win_q    <= 1'b0;
    end else if (new_game && (state_q == IDLE || state_q == OVER)) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      board_q  <= '0;
      status_q <= 2'b00;
      turn_q   <= 1'b0;
      count_q  <= '0;
      state_q  <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (btn_place) begin
            // A place on an occupied cell still consumes this cycle's action.
            if (ptr_empty) begin
              board_q[ptr_idx +: 2] <= stone;
              count_q <= count_q + CNT_W'(1);
              busy_q  <= 1'b1;
              org_x_q <= ptr_x_q;
              org_y_q <= ptr_y_q;
              color_q <= stone;
              dir_q   <= DIR_E;
              step_q  <= STEP_W'(1);
              run_q   <= RUN_W'(1);
              win_q   <= 1'b0;
              state_q <= CHECK;
            end
          end else if (btn_up) begin
            ptr_y_q <= ptr_y_q - COORD_W'(1);
          end else if (btn_down) begin
            ptr_y_q <= ptr_y_q + COORD_W'(1);
          end else if (btn_left) begin
            ptr_x_q <= ptr_x_q - COORD_W'(1);
          end else if (btn_right) begin
            ptr_x_q <= ptr_x_q + COORD_W'(1);
          end
        end

        CHECK: begin
          if (!ray_end) begin
            step_q <= step_q + STEP_W'(1);
            run_q  <= run_d;
          end else begin
            step_q <= STEP_W'(1);
            if (!dir_q[0]) begin
              // First ray of an axis done: keep its count for the opposite ray.
              dir_q <= dir_t'(dir_q + 3'd1);
              run_q <= run_d;
            end else if (run_d >= WIN_RUN) begin
              win_q   <= 1'b1;
              state_q <= EVAL;
            end else if (dir_q == DIR_NE) begin
              state_q <= EVAL;
            end else begin
              dir_q <= dir_t'(dir_q + 3'd1);
              run_q <= RUN_W'(1);
            end
          end
        end

        EVAL: begin
          busy_q <= 1'b0;
          if (win_q) begin
            status_q <= color_q;
            state_q  <= OVER;
          end else if (count_q == FULL_CNT) begin
            status_q <= 2'b11;
            state_q  <= OVER;
          end else begin
            turn_q  <= ~turn_q;
            state_q <= IDLE;
          end
        end

        OVER: ;

        default: state_q <= IDLE;
      endcase
    end
  end

  assign board         = board_q;
  assign pointer_loc_x = ptr_x_q;
  assign pointer_loc_y = ptr_y_q;
  assign gaming_status = status_q;
  assign turn          = turn_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_fivesons_game_ctrl.sv
// tb_fivesons_game_ctrl: directed bench for the FiveSons game controller.
module tb_fivesons_game_ctrl;

  localparam logic [5:0] B_NEW   = 6'b100000;
  localparam logic [5:0] B_PLACE = 6'b010000;
  localparam logic [5:0] B_UP    = 6'b001000;
  localparam logic [5:0] B_DOWN  = 6'b000100;
  localparam logic [5:0] B_RIGHT = 6'b000001;

  logic         clk = 1'b0;
  logic         rst;
  logic         new_game, btn_up, btn_down, btn_left, btn_right, btn_place;
  logic [511:0] board;
  logic [3:0]   px, py;
  logic [1:0]   status;
  logic         turn, busy;

  int checks = 0;
  int errors = 0;

  // Bench-side bookkeeping: cursor, expected board and expected side to move.
  int           cx, cy;
  logic [511:0] bexp;
  logic         tturn;
  int           lat;

  int bx[128], by[128], wx[128], wy[128];

  fivesons_game_ctrl dut (
    .Clck          (clk),
    .Reset         (rst),
    .new_game      (new_game),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_place     (btn_place),
    .board         (board),
    .pointer_loc_x (px),
    .pointer_loc_y (py),
    .gaming_status (status),
    .turn          (turn),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle button pulse; returns at the negedge after the sampling edge.
  task automatic pulse(input logic [5:0] m);
    @(negedge clk);
    {new_game, btn_place, btn_up, btn_down, btn_left, btn_right} = m;
    @(negedge clk);
    {new_game, btn_place, btn_up, btn_down, btn_left, btn_right} = '0;
  endtask

  task automatic move_to(input int x, input int y);
    while (cx != x) begin pulse(B_RIGHT); cx = (cx + 1) % 16; end
    while (cy != y) begin pulse(B_DOWN);  cy = (cy + 1) % 16; end
  endtask

  // Count negedges from the place pulse until busy falls, bounded.
  task automatic wait_done(output int l);
    l = 1;
    while (busy === 1'b1 && l < 40) begin
      @(negedge clk);
      l++;
    end
    if (busy !== 1'b0) check("busy_timeout", 512'(busy), 512'(0));
  endtask

  task automatic place_at(input int x, input int y, output int l);
    move_to(x, y);
    pulse(B_PLACE);
    bexp[x*2 + y*32 +: 2] = tturn ? 2'b10 : 2'b01;
    tturn = ~tturn;
    wait_done(l);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {new_game, btn_place, btn_up, btn_down, btn_left, btn_right} = '0;
    cx = 4; cy = 6; bexp = '0; tturn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_board",  board,  512'(0));
    check("rst_ptr_x",  512'(px), 512'(4));
    check("rst_ptr_y",  512'(py), 512'(6));
    check("rst_status", 512'(status), 512'(0));
    check("rst_turn",   512'(turn), 512'(0));
    check("rst_busy",   512'(busy), 512'(0));
    rst = 1'b0;

    // Place on an occupied cell is ignored.
    place_at(4, 6, lat);
    check("occ_first_board", board, bexp);
    check("occ_first_turn",  512'(turn), 512'(1));
    pulse(B_PLACE);
    check("occ_busy",  512'(busy), 512'(0));
    repeat (3) @(negedge clk);
    check("occ_board", board, bexp);
    check("occ_turn",  512'(turn), 512'(1));

    // Asynchronous reset in the middle of a check.
    move_to(5, 6);
    pulse(B_PLACE);
    check("midchk_busy", 512'(busy), 512'(1));
    #2 rst = 1'b1;
    #1;
    check("midchk_board", board, 512'(0));
    check("midchk_ptr",   512'({px, py}), 512'({4'd4, 4'd6}));
    check("midchk_busy0", 512'(busy), 512'(0));
    @(negedge clk);
    rst = 1'b0;
    cx = 4; cy = 6; bexp = '0; tturn = 1'b0;

    // Pointer wrap, priority, place + move in the same cycle.
    move_to(15, 0);
    check("ptr_15_0", 512'({px, py}), 512'({4'd15, 4'd0}));
    pulse(B_RIGHT);
    check("wrap_right", 512'({px, py}), 512'({4'd0, 4'd0}));
    pulse(B_UP);
    check("wrap_up", 512'({px, py}), 512'({4'd0, 4'd15}));
    cx = 0; cy = 15;
    pulse(B_PLACE | B_RIGHT);
    bexp[0*2 + 15*32 +: 2] = 2'b01;
    tturn = 1'b1;
    wait_done(lat);
    check("place_right_board", board, bexp);
    check("place_right_ptr",   512'({px, py}), 512'({4'd0, 4'd15}));
    pulse(B_UP | B_DOWN);
    check("prio_up_down", 512'(py), 512'(14));
    cy = 14;
    // new_game while busy is dropped.
    move_to(1, 14);
    pulse(B_PLACE);
    bexp[1*2 + 14*32 +: 2] = 2'b10;
    tturn = 1'b0;
    pulse(B_NEW);
    wait_done(lat);
    check("busy_newgame_board", board, bexp);
    check("busy_newgame_turn",  512'(turn), 512'(tturn));

    // Black five in a row along y=7.
    pulse(B_NEW);
    bexp = '0; tturn = 1'b0;
    check("ng_board", board, 512'(0));
    check("ng_turn",  512'(turn), 512'(0));
    check("ng_ptr",   512'({px, py}), 512'({4'd1, 4'd14}));
    for (int i = 0; i < 4; i++) begin
      place_at(i, 7, lat);
      place_at(i, 9, lat);
    end
    check("pre_win_status", 512'(status), 512'(0));
    place_at(4, 7, lat);
    check("black_win",     512'(status), 512'(1));
    check("black_win_lat", 512'(lat <= 34), 512'(1));
    check("black_board",   board, bexp);
    pulse(B_RIGHT);
    check("over_ptr_frozen", 512'({px, py}), 512'({4'd4, 4'd7}));
    pulse(B_PLACE);
    check("over_place_busy", 512'(busy), 512'(0));
    repeat (3) @(negedge clk);
    check("over_board",  board, bexp);
    check("over_status", 512'(status), 512'(1));
    check("over_turn",   512'(turn), 512'(0));

    // White diagonal completed in the middle.
    pulse(B_NEW);
    bexp = '0; tturn = 1'b0;
    place_at(0, 0, lat);   place_at(10, 10, lat);
    place_at(2, 0, lat);   place_at(11, 11, lat);
    place_at(4, 0, lat);   place_at(13, 13, lat);
    place_at(6, 0, lat);   place_at(14, 14, lat);
    place_at(8, 0, lat);
    check("pre_diag_status", 512'(status), 512'(0));
    place_at(12, 12, lat);
    check("white_win",     512'(status), 512'(2));
    check("white_win_lat", 512'(lat <= 34), 512'(1));
    check("white_board",   board, bexp);

    // Full board without any run longer than two: draw.
    pulse(B_NEW);
    bexp = '0; tturn = 1'b0;
    begin
      int nb, nw;
      nb = 0; nw = 0;
      for (int y = 0; y < 16; y++) begin
        for (int x = 0; x < 16; x++) begin
          if ((((x >> 1) + y) % 2) == 0) begin bx[nb] = x; by[nb] = y; nb++; end
          else begin wx[nw] = x; wy[nw] = y; nw++; end
        end
      end
    end
    for (int i = 0; i < 128; i++) begin
      place_at(bx[i], by[i], lat);
      if (i == 127) begin
        check("fill_255_status", 512'(status), 512'(0));
        check("fill_255_turn",   512'(turn), 512'(1));
      end
      place_at(wx[i], wy[i], lat);
    end
    check("draw_status", 512'(status), 512'(3));
    check("draw_board",  board, bexp);
    check("draw_busy",   512'(busy), 512'(0));
    pulse(B_NEW);
    check("draw_ng_board",  board, 512'(0));
    check("draw_ng_status", 512'(status), 512'(0));
    check("draw_ng_turn",   512'(turn), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
